// File: rtl/fxp_meansq.sv
// Streaming block mean-of-squares: squares each sample, sums N=2^LOG2N of them,
// divides by shift and emits a saturated WOI.WOF radicand for the sqrt stage.
module fxp_meansq #(
  parameter int WII   = 10,
  parameter int WIF   = 10,
  parameter int WOI   = 10,
  parameter int WOF   = 10,
  parameter int LOG2N = 2,
  parameter int ROUND = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WII+WIF-1:0]   in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WOI+WOF-1:0]   out,
  output logic                 overflow
);

  localparam int WI = WII + WIF;
  localparam int WP = 2 * WI;
  localparam int WA = WP + LOG2N;
  localparam int WO = WOI + WOF;
  localparam int FP = 2 * WIF;
  localparam int CW = (LOG2N > 0) ? LOG2N : 1;
  localparam int WX = WP + WOF + WOI + 2;

  logic          r_prod_valid;
  logic          r_prod_last;
  logic [WP-1:0] r_prod;
  logic [CW-1:0] r_cnt;
  logic [WA-1:0] r_acc;
  logic          r_out_valid;
  logic [WO-1:0] r_out;
  logic          r_ovf;

  logic                 w_stall;
  logic                 w_accept;
  logic                 w_adv;
  logic                 w_load;
  logic                 w_idx_last;
  logic signed [WP-1:0] w_sq;
  logic [WA-1:0]        w_sum;
  logic [WP-1:0]        w_mean;
  logic [WX-1:0]        w_mean_x;
  logic [WX-1:0]        w_conv;
  logic                 w_ovf;

  // Only a finished block waiting on a blocked output register can back up the input.
  assign w_stall    = r_prod_valid && r_prod_last && r_out_valid && !out_ready;
  assign in_ready   = !w_stall;
  assign w_accept   = in_valid && !w_stall;
  assign w_adv      = r_prod_valid && !w_stall;
  assign w_load     = w_adv && r_prod_last;
  assign w_idx_last = (LOG2N == 0) || (r_cnt == CW'((1 << LOG2N) - 1));

  assign w_sq     = $signed(in) * $signed(in);
  assign w_sum    = r_acc + WA'(r_prod);
  assign w_mean   = w_sum[WA-1:LOG2N];
  assign w_mean_x = WX'(w_mean);

  generate
    if (WOF < FP) begin : g_narrow
      localparam int SH = FP - WOF;
      logic [WX-1:0] w_half;
      assign w_half = (ROUND != 0) ? (WX'(1) << (SH - 1)) : '0;
      assign w_conv = (w_mean_x + w_half) >> SH;
    end else begin : g_widen
      assign w_conv = w_mean_x << (WOF - FP);
    end
  endgenerate

  // Result is non-negative, so any set bit at or above the sign position saturates.
  assign w_ovf = |(w_conv >> (WO - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod_valid <= 1'b0;
      r_prod_last  <= 1'b0;
      r_prod       <= '0;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_out_valid  <= 1'b0;
      r_out        <= '0;
      r_ovf        <= 1'b0;
    end else begin
      if (!w_stall) begin
        r_prod_valid <= w_accept;
        if (w_accept) begin
          r_prod      <= $unsigned(w_sq);
          r_prod_last <= w_idx_last;
        end
      end
      if (w_accept) begin
        r_cnt <= w_idx_last ? '0 : r_cnt + 1'b1;
      end
      if (w_adv) begin
        r_acc <= r_prod_last ? '0 : w_sum;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out       <= w_ovf ? {1'b0, {(WO-1){1'b1}}} : w_conv[WO-1:0];
        r_ovf       <= w_ovf;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_fxp_meansq.sv
// Bench for fxp_meansq: directed scenarios plus randomized traffic against an
// arithmetic model; a second instance with ROUND=0 shares the same stimulus.
module tb_fxp_meansq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_data;
  logic        overflow;
  logic        t_in_ready;
  logic        t_out_valid;
  logic [19:0] t_out;
  logic        t_ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fxp_meansq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out(out_data), .overflow(overflow)
  );

  fxp_meansq #(.ROUND(0)) dut_t (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready), .in(in_data),
    .out_valid(t_out_valid), .out_ready(out_ready), .out(t_out), .overflow(t_ovf)
  );

  // Mean of squares of four Q10.10 samples, rescaled to Q10.10 with saturation.
  function automatic logic [20:0] model(input logic [19:0] s[4], input int rnd);
    longint sum = 0;
    longint v;
    longint mean;
    longint q;
    for (int i = 0; i < 4; i++) begin
      v = longint'($signed(s[i]));
      sum += v * v;
    end
    mean = sum / 4;
    q = (rnd != 0) ? (mean + 512) / 1024 : mean / 1024;
    if (q > 524287) return 21'h17FFFF;
    return {1'b0, q[19:0]};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drive_block(input logic [19:0] s0, input logic [19:0] s1,
                             input logic [19:0] s2, input logic [19:0] s3,
                             output int lat, output logic [19:0] o, output logic ov,
                             output logic [19:0] ot, output logic ovt);
    logic [19:0] s[4];
    s = '{s0, s1, s2, s3};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = s[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    o = out_data; ov = overflow; ot = t_out; ovt = t_ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 20'h00400; out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 20'h0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_during: in_ready=%b out_valid=%b out=%h ovf=%b, want 1 0 00000 0",
               in_ready, out_valid, out_data, overflow);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_after: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic [19:0] o, ot; logic ov, ovt;
    do_reset();
    drive_block(20'h00400, 20'h00400, 20'h00400, 20'h00400, lat, o, ov, ot, ovt);
    n_cmp++;
    if (lat !== 2) begin n_err++; $display("FAIL basic_latency: got %0d want 2", lat); end
    n_cmp++;
    if (o !== 20'h00400 || ov !== 1'b0) begin
      n_err++; $display("FAIL basic_value: got %h ovf=%b want 00400 ovf=0", o, ov);
    end
  endtask

  task automatic test_negative();
    int lat; logic [19:0] o, ot; logic ov, ovt;
    do_reset();
    drive_block(20'h00800, 20'hFF800, 20'h00000, 20'h00000, lat, o, ov, ot, ovt);
    n_cmp++;
    if (o !== 20'h00800 || ov !== 1'b0) begin
      n_err++; $display("FAIL negative_value: got %h ovf=%b want 00800 ovf=0", o, ov);
    end
  endtask

  task automatic test_round();
    int lat; logic [19:0] o, ot; logic ov, ovt;
    do_reset();
    drive_block(20'h00020, 20'h00020, 20'h00000, 20'h00000, lat, o, ov, ot, ovt);
    n_cmp++;
    if (o !== 20'h00001) begin n_err++; $display("FAIL round_half_up: got %h want 00001", o); end
    n_cmp++;
    if (ot !== 20'h00000) begin n_err++; $display("FAIL round_truncate: got %h want 00000", ot); end
  endtask

  task automatic test_saturate();
    int lat; logic [19:0] o, ot; logic ov, ovt;
    do_reset();
    drive_block(20'h80000, 20'h80000, 20'h80000, 20'h80000, lat, o, ov, ot, ovt);
    n_cmp++;
    if (o !== 20'h7FFFF || ov !== 1'b1) begin
      n_err++; $display("FAIL saturate: got %h ovf=%b want 7FFFF ovf=1", o, ov);
    end
    n_cmp++;
    if (ot !== 20'h7FFFF || ovt !== 1'b1) begin
      n_err++; $display("FAIL saturate_trunc: got %h ovf=%b want 7FFFF ovf=1", ot, ovt);
    end
  endtask

  task automatic test_stall();
    logic [19:0] s[8];
    s = '{20'h00400, 20'h00400, 20'h00400, 20'h00400,
          20'h00800, 20'h00800, 20'h00800, 20'h00800};
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = s[i];
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++; $display("FAIL stall_ready_sample%0d: got %b want 1", i, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0 || t_in_ready !== 1'b0) begin
      n_err++; $display("FAIL stall_ready_drop: got %b/%b want 0/0", in_ready, t_in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 20'h00400 || overflow !== 1'b0) begin
      n_err++; $display("FAIL stall_first: valid=%b out=%h want 1 00400", out_valid, out_data);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 20'h00400 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL stall_hold: valid=%b out=%h rdy=%b want 1 00400 0",
                        out_valid, out_data, in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 20'h01000 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL stall_second: valid=%b out=%h rdy=%b want 1 01000 1",
                        out_valid, out_data, in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_drain: valid=%b want 0", out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_partial();
    int lat; logic [19:0] o, ot; logic ov, ovt;
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 20'h80000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL partial_no_output: valid=%b want 0", out_valid);
    end
    @(posedge clk); #1;
    drive_block(20'h00400, 20'h00400, 20'h00400, 20'h00400, lat, o, ov, ot, ovt);
    n_cmp++;
    if (lat !== 2 || o !== 20'h00400 || ov !== 1'b0) begin
      n_err++; $display("FAIL partial_block: lat=%0d out=%h ovf=%b want 2 00400 0", lat, o, ov);
    end
  endtask

  task automatic test_random(input int cycles, input int pv, input int pr);
    logic [19:0] blk[$];
    logic [20:0] expq[$];
    logic [20:0] expt[$];
    logic [20:0] e;
    logic [19:0] a[4];
    logic [19:0] prev_out;
    logic        prev_ovf;
    bit          hold_prev;
    int          v;
    hold_prev = 1'b0;
    prev_out  = '0;
    prev_ovf  = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < cycles + 10; cyc++) begin
      if (cyc < cycles) begin
        in_valid  = (pv >= 100) || ($urandom_range(0, 99) < pv);
        out_ready = (pr >= 100) || ($urandom_range(0, 99) < pr);
        v = ($urandom_range(0, 1) != 0) ? int'($urandom)
                                        : (int'($urandom_range(0, 32767)) - 16384);
        in_data = v[19:0];
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
      @(negedge clk);
      if (hold_prev) begin
        n_cmp++;
        if (out_data !== prev_out || overflow !== prev_ovf || out_valid !== 1'b1) begin
          n_err++; $display("FAIL rand_hold: out=%h ovf=%b valid=%b want %h %b 1",
                            out_data, overflow, out_valid, prev_out, prev_ovf);
        end
      end
      if (pv >= 100 && pr >= 100 && cyc < cycles) begin
        n_cmp++;
        if (in_ready !== 1'b1) begin
          n_err++; $display("FAIL rand_throughput cyc%0d: in_ready=%b want 1", cyc, in_ready);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (expq.size() == 0) begin
          n_err++; $display("FAIL rand_unexpected: out=%h with nothing expected", out_data);
        end else begin
          e = expq.pop_front();
          if ({overflow, out_data} !== e) begin
            n_err++; $display("FAIL rand_round: out=%h ovf=%b want %h ovf=%b",
                              out_data, overflow, e[19:0], e[20]);
          end
        end
      end
      if (t_out_valid && out_ready) begin
        n_cmp++;
        if (expt.size() == 0) begin
          n_err++; $display("FAIL rand_t_unexpected: out=%h with nothing expected", t_out);
        end else begin
          e = expt.pop_front();
          if ({t_ovf, t_out} !== e) begin
            n_err++; $display("FAIL rand_trunc: out=%h ovf=%b want %h ovf=%b",
                              t_out, t_ovf, e[19:0], e[20]);
          end
        end
      end
      if (in_valid && in_ready) begin
        blk.push_back(in_data);
        if (blk.size() == 4) begin
          for (int i = 0; i < 4; i++) a[i] = blk[i];
          expq.push_back(model(a, 1));
          expt.push_back(model(a, 0));
          blk.delete();
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_out  = out_data;
      prev_ovf  = overflow;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (expq.size() != 0 || expt.size() != 0) begin
      n_err++; $display("FAIL rand_missing: %0d/%0d results never delivered",
                        expq.size(), expt.size());
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    test_reset();
    test_basic();
    test_negative();
    test_round();
    test_saturate();
    test_stall();
    test_reset_partial();
    test_random(400, 100, 100);
    test_random(1500, 70, 50);
    test_random(800, 90, 20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
